// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential instmem reads from an internal PC, in-order
// response tagging, and an output queue drained by decode/execute (valid/ready).
// Handshakes: a request or head pop transfers only on a rising edge where valid && ready.
module fetch_unit #(
    parameter int              Xlen           = 32,
    parameter int              Ilen           = 32,
    parameter int              DepthLog2      = 2,
    parameter int              MaxOutstanding = 2,
    parameter logic [Xlen-1:0] ResetPc        = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              redirect_valid_i,
    input  logic [Xlen-1:0]   redirect_pc_i,
    input  logic              instmem_ready_i,
    output logic              instmem_valid_o,
    output logic [Xlen-1:0]   instmem_addr_o,
    output logic [Ilen-1:0]   instmem_wdata_o,
    output logic [Ilen/8-1:0] instmem_wmask_o,
    input  logic [Ilen-1:0]   instmem_rdata_i,
    input  logic              instmem_rvalid_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [Xlen-1:0]   out_pc_o,
    output logic [Ilen-1:0]   out_inst_o
);

    localparam int              Depth   = 2 ** DepthLog2;
    localparam int              TagIdxW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int              TagCntW = $clog2(MaxOutstanding + 1);
    localparam int              SumW    = TagCntW + DepthLog2 + 2;
    localparam logic [Xlen-1:0] PcStep  = Xlen'(Ilen / 8);

    logic [Xlen-1:0]           pc_q;
    logic [Xlen-1:0]           fetch_addr;

    logic [Xlen-1:0]           tag_pc_q [MaxOutstanding];
    logic [MaxOutstanding-1:0] tag_drop_q;
    logic [TagIdxW-1:0]        tag_rd_q;
    logic [TagIdxW-1:0]        tag_wr_q;
    logic [TagCntW-1:0]        tag_cnt_q;

    logic [Xlen-1:0]           outq_pc_q   [Depth];
    logic [Ilen-1:0]           outq_inst_q [Depth];
    logic [DepthLog2-1:0]      outq_rd_q;
    logic [DepthLog2-1:0]      outq_wr_q;
    logic [DepthLog2:0]        outq_cnt_q;

    logic [SumW-1:0]           occupancy;
    logic                      req_fire;
    logic                      rsp_fire;
    logic                      rsp_keep;
    logic                      out_pop;
    logic                      unused_pc_bits;

    // The low target bits are defined as don't-care.
    assign unused_pc_bits = ^redirect_pc_i[1:0];

    function automatic logic [TagIdxW-1:0] next_tag(input logic [TagIdxW-1:0] idx);
        return (idx == TagIdxW'(MaxOutstanding - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign fetch_addr = redirect_valid_i ? {redirect_pc_i[Xlen-1:2], 2'b00} : pc_q;

    // Every in-flight live request owns a queue slot; a redirect frees the whole queue.
    assign occupancy = SumW'(tag_cnt_q) + (redirect_valid_i ? SumW'(0) : SumW'(outq_cnt_q));

    assign instmem_valid_o = !rst_i && (tag_cnt_q < TagCntW'(MaxOutstanding))
                             && (occupancy < SumW'(Depth));
    assign instmem_addr_o  = fetch_addr;
    assign instmem_wdata_o = '0;
    assign instmem_wmask_o = '0;

    assign req_fire = instmem_valid_o && instmem_ready_i;
    assign rsp_fire = instmem_rvalid_i && (tag_cnt_q != '0);
    assign rsp_keep = rsp_fire && !tag_drop_q[tag_rd_q] && !redirect_valid_i;
    assign out_pop  = out_ready_i && (outq_cnt_q != '0) && !redirect_valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= ResetPc;
        end else if (req_fire) begin
            pc_q <= fetch_addr + PcStep;
        end else if (redirect_valid_i) begin
            pc_q <= fetch_addr;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_drop_q <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            tag_cnt_q  <= '0;
        end else begin
            // Kill everything already in flight; the target request written below stays live.
            if (redirect_valid_i) begin
                tag_drop_q <= '1;
            end
            if (req_fire) begin
                tag_drop_q[tag_wr_q] <= 1'b0;
                tag_wr_q             <= next_tag(tag_wr_q);
            end
            if (rsp_fire) begin
                tag_rd_q <= next_tag(tag_rd_q);
            end
            case ({req_fire, rsp_fire})
                2'b10:   tag_cnt_q <= tag_cnt_q + 1'b1;
                2'b01:   tag_cnt_q <= tag_cnt_q - 1'b1;
                default: tag_cnt_q <= tag_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_fire) begin
            tag_pc_q[tag_wr_q] <= fetch_addr;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outq_rd_q  <= '0;
            outq_wr_q  <= '0;
            outq_cnt_q <= '0;
        end else if (redirect_valid_i) begin
            outq_rd_q  <= '0;
            outq_wr_q  <= '0;
            outq_cnt_q <= '0;
        end else begin
            if (rsp_keep) begin
                outq_wr_q <= outq_wr_q + 1'b1;
            end
            if (out_pop) begin
                outq_rd_q <= outq_rd_q + 1'b1;
            end
            case ({rsp_keep, out_pop})
                2'b10:   outq_cnt_q <= outq_cnt_q + 1'b1;
                2'b01:   outq_cnt_q <= outq_cnt_q - 1'b1;
                default: outq_cnt_q <= outq_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rsp_keep) begin
            outq_pc_q[outq_wr_q]   <= tag_pc_q[tag_rd_q];
            outq_inst_q[outq_wr_q] <= instmem_rdata_i;
        end
    end

    assign out_valid_o = (outq_cnt_q != '0);
    assign out_pc_o    = outq_pc_q[outq_rd_q];
    assign out_inst_o  = outq_inst_q[outq_rd_q];

    rvalid_needs_tag: assert property (@(posedge clk_i) disable iff (rst_i)
        instmem_rvalid_i |-> (tag_cnt_q != '0));

    outq_never_overflows: assert property (@(posedge clk_i) disable iff (rst_i)
        (rsp_keep && !out_pop) |-> (outq_cnt_q < (DepthLog2 + 1)'(Depth)));

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the Harvard core.
- Issues sequential instruction-memory reads from an internal PC with up to MaxOutstanding requests in flight.
- Pairs each response with its PC and buffers {pc, inst} in an output queue that the decode/execute stage drains with a valid/ready handshake.
- On a redirect (jump or taken branch), flushes the queue, re-targets fetch in the same cycle, and discards every response still in flight from the old path.

Parameters:
- Xlen, 32, PC/address width.
- Ilen, 32, instruction width; PC increment is Ilen/8.
- DepthLog2, 2, output-queue depth is 2**DepthLog2 entries.
- MaxOutstanding, 2, maximum issued-but-unanswered instmem requests (>=1).
- ResetPc, 0, PC value after reset.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- redirect_valid_i  in  1  redirect the fetch PC this cycle.
- redirect_pc_i  in  Xlen  redirect target; bits [1:0] are ignored and treated as 0.
- instmem_ready_i  in  1  memory accepts a request.
- instmem_valid_o  out  1  request valid.
- instmem_addr_o  out  Xlen  request address.
- instmem_wdata_o  out  Ilen  constant 0.
- instmem_wmask_o  out  Ilen/8  constant 0 (read only).
- instmem_rdata_i  in  Ilen  response data.
- instmem_rvalid_i  in  1  response valid; responses return in order, at least 1 cycle after acceptance.
- out_valid_o  out  1  queue head valid.
- out_ready_i  in  1  consumer pops the head.
- out_pc_o  out  Xlen  PC of the head instruction.
- out_inst_o  out  Ilen  head instruction.

Behaviour:
- Reset, asynchronous: pc_q=ResetPc; queue empty; tag queue empty.
  - instmem_valid_o=0 and out_valid_o=0 while rst_i is high.
  - First request is issued in the first cycle after deassertion, at address ResetPc.
- Fetch address:
  - addr = redirect_valid_i ? {redirect_pc_i[Xlen-1:2],2'b0} : pc_q (combinational bypass).
  - On request accept (valid&&ready): pc_q <= addr + Ilen/8, wrapping modulo 2**Xlen.
  - On a redirect without accept: pc_q <= the redirect address.
- Tag queue:
  - In-order FIFO of MaxOutstanding entries, each holding {pc, drop}.
  - Push {addr, 0} on request accept; pop on instmem_rvalid_i.
- Issue condition: instmem_valid_o = !rst_i && tagq_count<MaxOutstanding && (tagq_count + (redirect ? 0 : outq_count)) < 2**DepthLog2.
  - Ensures every live response has guaranteed queue space; the queue never overflows.
- Response handling:
  - Popped tag with drop=0: push {tag.pc, rdata} into the output queue.
  - drop=1: discard the data; the output queue is unchanged.
- Redirect cycle:
  - Every tag-queue entry present at the start of the cycle gets drop=1, including one popped this same cycle, whose response is discarded.
  - The entry pushed this cycle (the redirect-target request) keeps drop=0.
  - The output queue is emptied. A same-cycle pop is ignored, and a same-cycle response is discarded.
  - out_valid_o still reflects the pre-flush head combinationally. The consumer is the redirect source and must not act on it.
- Output queue:
  - Standard FIFO: out_valid_o = count!=0; head data is driven combinationally.
  - Simultaneous push and pop while full: impossible by the issue rule.
  - Simultaneous push and pop while empty: the push lands and the pop is ignored (out_valid_o was 0).
- Throughput: one instruction per cycle sustained when memory latency is 1, MaxOutstanding>=2, and the consumer is always ready.
- instmem_rvalid_i with an empty tag queue is a protocol violation: ignored, with a simulation assertion.
- Reset mid-operation: all state clears at once; responses to pre-reset requests arriving after reset are a memory-side violation (assertion).

Test Plan:
- Reset with ResetPc=0x100, memory latency 1, out_ready_i=1 -> requests at 0x100,0x104,0x108...; out_pc_o follows the same sequence one cycle after each request, one per cycle.
- out_ready_i=0 and depth 4 -> exactly 4 requests issued (0x0-0xC), then instmem_valid_o=0; a single pop -> exactly one new request, at 0x10.
- MaxOutstanding=2, latency 3, two requests in flight (0x8,0xC), redirect to 0x40 -> both old responses discarded; first out_pc_o=0x40, then 0x44.
- Redirect to 0x80 in the same cycle as the response for 0x4 -> 0x4 never appears at the output; the next output is 0x80.
- Redirect_pc_i=0x43 -> instmem_addr_o=0x40, and pc_q advances to 0x44.
- rst_i pulsed mid-stream with the queue full and requests in flight -> out_valid_o=0 immediately (asynchronous), and after release fetch restarts at ResetPc with an empty queue.
